alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq.sv | 139 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequencer driving the 16-bit ALU through shift-add multiply
// and restoring divide, one ALU transaction per cycle.
module alu_muldiv_seq (
   input  logic        clk,
   input  logic        resetLow,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] opHi,
   input  logic [15:0] opLo,
   input  logic [15:0] opD,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] resHi,
   output logic [15:0] resLo,
   output logic [3:0]  aluS,
   output logic        aluM,
   output logic        aluCI,
   output logic [15:0] aluA,
   output logic [15:0] aluB,
   input  logic [15:0] aluZ,
   input  logic        aluCO
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_MUL   = 3'd2;
   localparam logic [2:0] ST_DIV   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]  r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_acc;
   logic [15:0] r_lo;
   logic [15:0] r_b;
   logic        r_err;

   logic        w_msb;
   logic [15:0] w_sh;
   logic        w_qbit;
   logic        w_last;

   assign w_msb  = r_acc[15];
   assign w_sh   = {r_acc[14:0], r_lo[15]};
   assign w_qbit = w_msb | aluCO;
   assign w_last = (r_cnt == 4'd15);

   // ALU controls decode straight from registered state
   always_comb begin
      aluS  = 4'b1111;
      aluM  = 1'b1;
      aluCI = 1'b1;
      aluA  = 16'h0000;
      aluB  = 16'h0000;
      case (r_state)
         ST_MUL: begin
            aluA = r_acc;
            aluB = r_b;
            if (r_lo[0]) begin
               aluS = 4'b1001;
               aluM = 1'b0;
            end
         end
         ST_CHECK: begin
            aluS  = 4'b0110;
            aluM  = 1'b0;
            aluCI = 1'b0;
            aluA  = r_acc;
            aluB  = r_b;
         end
         ST_DIV: begin
            aluS  = 4'b0110;
            aluM  = 1'b0;
            aluCI = 1'b0;
            aluA  = w_sh;
            aluB  = r_b;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetLow) begin
      if (!resetLow) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_acc   <= 16'h0000;
         r_lo    <= 16'h0000;
         r_b     <= 16'h0000;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_acc   <= op ? opHi : 16'h0000;
                  r_lo    <= opLo;
                  r_b     <= op ? opD : opHi;
                  r_err   <= 1'b0;
                  r_cnt   <= 4'd0;
                  r_state <= op ? ST_CHECK : ST_MUL;
               end
            end
            ST_CHECK: begin
               // high word >= divisor means the quotient overflows
               if ((r_b == 16'h0000) || aluCO) begin
                  r_err   <= 1'b1;
                  r_acc   <= 16'hFFFF;
                  r_lo    <= 16'hFFFF;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_DIV;
               end
            end
            ST_MUL: begin
               r_acc <= {~aluCO, aluZ[15:1]};
               r_lo  <= {aluZ[0], r_lo[15:1]};
               r_cnt <= r_cnt + 4'd1;
               if (w_last) r_state <= ST_DONE;
            end
            ST_DIV: begin
               r_acc <= w_qbit ? aluZ : w_sh;
               r_lo  <= {r_lo[14:0], w_qbit};
               r_cnt <= r_cnt + 4'd1;
               if (w_last) r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy  = (r_state == ST_CHECK) ||
                  (r_state == ST_MUL) ||
                  (r_state == ST_DIV);
   assign done  = (r_state == ST_DONE);
   assign err   = r_err;
   assign resHi = r_acc;
   assign resLo = r_lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU, reference model
// and a scoreboard queue of expected results.
module tb_alu_muldiv_seq;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk;
   logic        resetLow;
   logic        start;
   logic        op;
   logic [15:0] opHi;
   logic [15:0] opLo;
   logic [15:0] opD;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] resHi;
   logic [15:0] resLo;
   logic [3:0]  aluS;
   logic        aluM;
   logic        aluCI;
   logic [15:0] aluA;
   logic [15:0] aluB;
   logic [15:0] aluZ;
   logic        aluCO;

   int n_tests;
   int n_fail;
   exp_t sb[$];

   alu_muldiv_seq dut (
      .clk(clk), .resetLow(resetLow),
      .start(start), .op(op),
      .opHi(opHi), .opLo(opLo), .opD(opD),
      .busy(busy), .done(done), .err(err),
      .resHi(resHi), .resLo(resLo),
      .aluS(aluS), .aluM(aluM), .aluCI(aluCI),
      .aluA(aluA), .aluB(aluB),
      .aluZ(aluZ), .aluCO(aluCO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU behaviour for the three encodings the sequencer uses
   always_comb begin
      logic [16:0] t;
      t     = 17'd0;
      aluZ  = 16'h0000;
      aluCO = 1'b1;
      case ({aluS, aluM, aluCI})
         6'b1001_0_1: begin
            t     = {1'b0, aluA} + {1'b0, aluB};
            aluZ  = t[15:0];
            aluCO = ~t[16];
         end
         6'b0110_0_0: begin
            t     = {1'b0, aluA} + {1'b0, ~aluB} + 17'd1;
            aluZ  = t[15:0];
            aluCO = t[16];
         end
         6'b1111_1_1: begin
            aluZ  = aluA;
            aluCO = 1'b1;
         end
         default: ;
      endcase
   end

   function automatic exp_t model(input logic o,
                                  input logic [15:0] h,
                                  input logic [15:0] l,
                                  input logic [15:0] d);
      exp_t e;
      logic [31:0] p;
      if (!o) begin
         p = {16'h0, h} * {16'h0, l};
         e.hi = p[31:16];
         e.lo = p[15:0];
         e.err = 1'b0;
         e.lat = 17;
      end else if (d == 16'h0 || h >= d) begin
         e.hi = 16'hFFFF;
         e.lo = 16'hFFFF;
         e.err = 1'b1;
         e.lat = 2;
      end else begin
         p = {h, l} / {16'h0, d};
         e.lo = p[15:0];
         p = {h, l} % {16'h0, d};
         e.hi = p[15:0];
         e.err = 1'b0;
         e.lat = 18;
      end
      return e;
   endfunction

   // Caller is at a negedge; returns at the negedge after done.
   // glitch > 0 pulses a junk start at that cycle of the run.
   task automatic run_op(input logic o,
                         input logic [15:0] h,
                         input logic [15:0] l,
                         input logic [15:0] d,
                         input int glitch,
                         input string name);
      exp_t e;
      int n;
      sb.push_back(model(o, h, l, d));
      op = o; opHi = h; opLo = l; opD = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy: got %b want 1", name, busy);
      end
      while (done !== 1'b1 && n < 60) begin
         if (n == glitch) begin
            start = 1'b1;
            op = ~o;
            opHi = 16'h1234; opLo = 16'h5678; opD = 16'h0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (n != e.lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d",
                  name, n, e.lat);
      end
      n_tests++;
      if (resHi !== e.hi || resLo !== e.lo) begin
         n_fail++;
         $display("FAIL %s result: got %h_%h want %h_%h",
                  name, resHi, resLo, e.hi, e.lo);
      end
      n_tests++;
      if (err !== e.err || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s err/busy: got %b/%b want %b/0",
                  name, err, busy, e.err);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || resHi !== e.hi ||
          resLo !== e.lo || err !== e.err) begin
         n_fail++;
         $display("FAIL %s hold: got d%b %h_%h e%b want d0 %h_%h e%b",
                  name, done, resHi, resLo, err,
                  e.hi, e.lo, e.err);
      end
   endtask

   task automatic test_reset();
      resetLow = 1'b0;
      start = 1'b0;
      op = 1'b0; opHi = 16'h0; opLo = 16'h0; opD = 16'h0;
      #12;
      n_tests++;
      if ({busy, done, err} !== 3'b000 ||
          resHi !== 16'h0 || resLo !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b%b%b %h_%h want 000 0_0",
                  busy, done, err, resHi, resLo);
      end
      n_tests++;
      if ({aluS, aluM, aluCI} !== 6'b1111_1_1 ||
          aluA !== 16'h0 || aluB !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_alu: got %b %b %b %h %h want PASS 0 0",
                  aluS, aluM, aluCI, aluA, aluB);
      end
      @(negedge clk);
      resetLow = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      run_op(1'b0, 16'h0003, 16'h0005, 16'h0, 0, "mul_3x5");
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 0, "mul_max");
      run_op(1'b0, 16'h0000, 16'hABCD, 16'h0, 0, "mul_zero");
   endtask

   task automatic test_div();
      run_op(1'b1, 16'h0001, 16'h0000, 16'h0003, 0, "div_1_3");
      run_op(1'b1, 16'h8000, 16'h0000, 16'hFFFF, 0, "div_msb");
      run_op(1'b1, 16'h0000, 16'h0007, 16'h0007, 0, "div_exact");
   endtask

   task automatic test_fault();
      run_op(1'b1, 16'h0005, 16'h1111, 16'h0000, 0, "div_by0");
      run_op(1'b1, 16'h0005, 16'h0000, 16'h0005, 0, "div_ovf");
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 16'h1234, 16'h0101, 16'h0, 0, "b2b_mul");
      run_op(1'b1, 16'h0012, 16'h3456, 16'h0100, 0, "b2b_div");
      run_op(1'b1, 16'hFFFF, 16'h0000, 16'h0001, 0, "b2b_flt");
   endtask

   task automatic test_busy_start();
      run_op(1'b0, 16'h0007, 16'h0009, 16'h0, 5, "mul_glitch");
      run_op(1'b1, 16'h0002, 16'h0000, 16'h0007, 9, "div_glitch");
   endtask

   task automatic test_random();
      logic o;
      logic [15:0] h, l, d;
      for (int i = 0; i < 10; i++) begin
         o = i[0];
         h = 16'($urandom);
         l = 16'($urandom);
         d = 16'($urandom);
         if (o && d != 16'h0) h = h % d;
         run_op(o, h, l, d, 0, "random");
      end
   endtask

   task automatic test_reset_midop();
      int pulses;
      op = 1'b0; opHi = 16'h00FF; opLo = 16'h00FF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      resetLow = 1'b0;
      #1;
      n_tests++;
      if ({busy, done} !== 2'b00 ||
          resHi !== 16'h0 || resLo !== 16'h0) begin
         n_fail++;
         $display("FAIL midop_reset: got %b%b %h_%h want 00 0_0",
                  busy, done, resHi, resLo);
      end
      @(negedge clk);
      resetLow = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL midop_nodone: got %0d active cycles want 0",
                  pulses);
      end
      run_op(1'b0, 16'h0101, 16'h0003, 16'h0, 0, "after_reset");
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      test_reset();
      test_mul();
      test_div();
      test_fault();
      test_back_to_back();
      test_busy_start();
      test_random();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
